// File: rtl/step_ctrl_pkg.sv
//------------------------------------------------------------------------------
// step_ctrl_pkg : state encoding and default widths for the run/step controller
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package step_ctrl_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int BURST_W_DEF = 8;
    localparam int CNT_W_DEF   = 32;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2,
        ST_BREAK = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/step_bp_match.sv
//------------------------------------------------------------------------------
// step_bp_match : PC breakpoint compare with one-shot skip after a BREAK exit
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module step_bp_match
    import step_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_en,
    input  logic              cpu_en,
    input  logic              set_skip,
    output logic              match
);

    logic skip_q;
    logic skip_d;

    // skip lets the resumed instruction at the breakpoint retire once
    always_comb begin
        skip_d = skip_q;
        if (set_skip) begin
            skip_d = 1'b1;
        end else if (cpu_en) begin
            skip_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            skip_q <= 1'b0;
        end else begin
            skip_q <= skip_d;
        end
    end

    assign match = bp_en & (pc == bp_addr) & ~skip_q;

endmodule

`default_nettype wire

// File: rtl/step_ctrl.sv
//------------------------------------------------------------------------------
// step_ctrl : run / single-step / burst controller producing the core enable.
//             Optional breakpoint halt under STEP_CTRL_BREAKPOINT_EN.
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BURST_W = BURST_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_pulse,
    input  logic               run_sw,
    input  logic               halt_req,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [ADDR_W-1:0]  pc,
    input  logic [ADDR_W-1:0]  bp_addr,
    input  logic               bp_en,
    output logic               cpu_en,
    output logic               halted,
    output logic               bp_hit,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   instr_count
);

    state_e             state_q,       state_d;
    logic [BURST_W-1:0] remaining_q,   remaining_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;

    logic               match;
    logic               set_skip;
    logic               cpu_en_fsm;
    logic [BURST_W-1:0] burst_load;

    assign burst_load = (burst_len == '0) ? BURST_W'(1) : burst_len;

`ifdef STEP_CTRL_BREAKPOINT_EN
    step_bp_match #(
        .ADDR_W   (ADDR_W)
    ) u_bp_match (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc),
        .bp_addr  (bp_addr),
        .bp_en    (bp_en),
        .cpu_en   (cpu_en),
        .set_skip (set_skip),
        .match    (match)
    );
`else
    logic unused_bp;
    assign match     = 1'b0;
    assign unused_bp = ^{pc, bp_addr, bp_en, set_skip};
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cpu_en_fsm  = 1'b0;
        set_skip    = 1'b0;

        unique case (state_q)
            ST_HALT: begin
                if (!halt_req) begin
                    if (run_sw) begin
                        state_d = ST_RUN;
                    end else if (step_pulse) begin
                        state_d     = ST_BURST;
                        remaining_d = burst_load;
                    end
                end
            end

            ST_RUN: begin
                cpu_en_fsm = ~match & ~halt_req;
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (match) begin
                    state_d = ST_BREAK;
                end else if (!run_sw) begin
                    state_d = ST_HALT;
                end
            end

            ST_BURST: begin
                cpu_en_fsm = ~match & ~halt_req;
                if (halt_req) begin
                    state_d     = ST_HALT;
                    remaining_d = '0;
                end else if (match) begin
                    state_d     = ST_BREAK;
                    remaining_d = '0;
                end else begin
                    // A zero count here is unreachable but is treated as last.
                    if (remaining_q <= BURST_W'(1)) begin
                        state_d     = ST_HALT;
                        remaining_d = '0;
                    end else begin
                        remaining_d = remaining_q - BURST_W'(1);
                    end
                end
            end

            ST_BREAK: begin
                if (halt_req || !run_sw) begin
                    state_d = ST_HALT;
                end else if (step_pulse) begin
                    state_d     = ST_BURST;
                    remaining_d = burst_load;
                end
                set_skip = (state_d != ST_BREAK);
            end

            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Enable is killed combinationally while reset is asserted.
    assign cpu_en        = cpu_en_fsm & rst;
    assign instr_count_d = instr_count_q + (cpu_en ? CNT_W'(1) : CNT_W'(0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_HALT;
            remaining_q   <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign state       = state_q;
    assign halted      = (state_q == ST_HALT) || (state_q == ST_BREAK);
    assign bp_hit      = (state_q == ST_BREAK);
    assign instr_count = instr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_step_ctrl.sv
//------------------------------------------------------------------------------
// tb_step_ctrl : vector-table and scoreboard bench for step_ctrl (CNT_W = 4)
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_step_ctrl;

    localparam int ADDR_W  = 32;
    localparam int BURST_W = 8;
    localparam int CNT_W   = 4;
    localparam logic [31:0] BP = 32'h0040_0010;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               step_pulse = 1'b0;
    logic               run_sw = 1'b0;
    logic               halt_req = 1'b0;
    logic [BURST_W-1:0] burst_len = '0;
    logic [ADDR_W-1:0]  pc = '0;
    logic [ADDR_W-1:0]  bp_addr = BP;
    logic               bp_en = 1'b0;
    logic               cpu_en;
    logic               halted;
    logic               bp_hit;
    logic [1:0]         state;
    logic [CNT_W-1:0]   instr_count;

    step_ctrl #(
        .ADDR_W      (ADDR_W),
        .BURST_W     (BURST_W),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .step_pulse  (step_pulse),
        .run_sw      (run_sw),
        .halt_req    (halt_req),
        .burst_len   (burst_len),
        .pc          (pc),
        .bp_addr     (bp_addr),
        .bp_en       (bp_en),
        .cpu_en      (cpu_en),
        .halted      (halted),
        .bp_hit      (bp_hit),
        .state       (state),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        run;
        logic        step;
        logic        halt;
        logic [7:0]  bl;
        logic [31:0] pc;
        logic        bpe;
        logic [1:0]  st;
        logic        cpu;
        logic [3:0]  cnt;
    } vec_t;

    typedef struct {
        logic [1:0] st;
        logic       cpu;
        logic [3:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void v(input logic r, input logic run, input logic stp, input logic hlt,
                              input logic [7:0] bl, input logic [31:0] p, input logic bpe,
                              input logic [1:0] st, input logic cpu, input logic [3:0] cnt);
        vec_t e;
        e.rst = r; e.run = run; e.step = stp; e.halt = hlt; e.bl = bl;
        e.pc = p; e.bpe = bpe; e.st = st; e.cpu = cpu; e.cnt = cnt;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        int   base;
        logic [3:0] exp_cnt;

        //  rst run stp hlt bl  pc              bpe st cpu cnt
        v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        v(1, 1, 0, 0, 0, 0, 0, 1, 1, 1);
        v(1, 0, 0, 0, 0, 0, 0, 1, 1, 2);
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        // burst of 5 with a stray pulse in the middle
        v(1, 0, 1, 0, 5, 0, 0, 0, 0, 3);
        v(1, 0, 0, 0, 5, 0, 0, 2, 1, 3);
        v(1, 0, 1, 0, 5, 0, 0, 2, 1, 4);
        v(1, 0, 0, 0, 5, 0, 0, 2, 1, 5);
        v(1, 0, 0, 0, 5, 0, 0, 2, 1, 6);
        v(1, 0, 0, 0, 5, 0, 0, 2, 1, 7);
        v(1, 0, 0, 0, 5, 0, 0, 0, 0, 8);
        // burst_len 0 behaves as 1
        v(1, 0, 1, 0, 0, 0, 0, 0, 0, 8);
        v(1, 0, 0, 0, 0, 0, 0, 2, 1, 8);
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 9);
        // halt_req mid-burst, then a fresh burst of 2
        v(1, 0, 1, 0, 5, 0, 0, 0, 0, 9);
        v(1, 0, 0, 0, 5, 0, 0, 2, 1, 9);
        v(1, 0, 0, 0, 5, 0, 0, 2, 1, 10);
        v(1, 0, 0, 1, 5, 0, 0, 2, 0, 11);
        v(1, 0, 1, 1, 5, 0, 0, 0, 0, 11);
        v(1, 0, 1, 0, 2, 0, 0, 0, 0, 11);
        v(1, 0, 0, 0, 2, 0, 0, 2, 1, 11);
        v(1, 0, 0, 0, 2, 0, 0, 2, 1, 12);
        // run and step together: run wins; counter wraps 15 -> 0
        v(1, 1, 1, 0, 2, 0, 0, 0, 0, 13);
        v(1, 1, 0, 0, 2, 0, 0, 1, 1, 13);
        v(1, 1, 0, 0, 2, 0, 0, 1, 1, 14);
        v(1, 1, 0, 0, 2, 0, 0, 1, 1, 15);
        v(1, 1, 0, 0, 2, 0, 0, 1, 1, 0);
        v(1, 1, 0, 0, 2, 0, 0, 1, 1, 1);
        v(1, 1, 0, 1, 2, 0, 0, 1, 0, 2);
        v(1, 1, 0, 0, 2, 0, 0, 0, 0, 2);
        v(1, 1, 0, 0, 2, 0, 0, 1, 1, 2);
        v(1, 0, 0, 0, 2, 0, 0, 1, 1, 3);
        // run_sw during a burst only takes effect after it completes
        v(1, 0, 1, 0, 1, 0, 0, 0, 0, 4);
        v(1, 1, 0, 0, 1, 0, 0, 2, 1, 4);
        v(1, 1, 0, 0, 1, 0, 0, 0, 0, 5);
        v(1, 0, 0, 0, 1, 0, 0, 1, 1, 5);
        v(1, 0, 0, 0, 1, 0, 0, 0, 0, 6);
        // reset mid-burst
        v(1, 0, 1, 0, 3, 0, 0, 0, 0, 6);
        v(1, 0, 0, 0, 3, 0, 0, 2, 1, 6);
        v(0, 0, 0, 0, 3, 0, 0, 2, 0, 7);
        v(1, 0, 0, 0, 3, 0, 0, 0, 0, 0);
`ifdef STEP_CTRL_BREAKPOINT_EN
        v(1, 1, 0, 0, 1, BP - 4, 1, 0, 0, 0);
        v(1, 1, 0, 0, 1, BP - 4, 1, 1, 1, 0);
        v(1, 1, 0, 0, 1, BP,     1, 1, 0, 1);
        v(1, 1, 0, 0, 1, BP,     1, 3, 0, 1);
        v(1, 1, 1, 0, 1, BP,     1, 3, 0, 1);
        v(1, 1, 0, 0, 1, BP,     1, 2, 1, 1);
        v(1, 0, 0, 0, 1, BP,     1, 0, 0, 2);
        v(1, 1, 0, 0, 1, BP,     1, 0, 0, 2);
        v(1, 1, 0, 0, 1, BP,     1, 1, 0, 2);
        v(1, 0, 0, 0, 1, BP,     1, 3, 0, 2);
        v(1, 1, 0, 0, 1, BP,     1, 0, 0, 2);
        v(1, 1, 0, 0, 1, BP,     1, 1, 1, 2);
        v(1, 1, 0, 0, 1, BP + 4, 1, 1, 1, 3);
`else
        v(1, 1, 0, 0, 1, BP - 4, 1, 0, 0, 0);
        v(1, 1, 0, 0, 1, BP - 4, 1, 1, 1, 0);
        v(1, 1, 0, 0, 1, BP,     1, 1, 1, 1);
        v(1, 1, 0, 0, 1, BP,     1, 1, 1, 2);
        v(1, 1, 1, 0, 1, BP,     1, 1, 1, 3);
        v(1, 1, 0, 0, 1, BP,     1, 1, 1, 4);
        v(1, 0, 0, 0, 1, BP,     1, 1, 1, 5);
        v(1, 1, 0, 0, 1, BP,     1, 0, 0, 6);
        v(1, 1, 0, 0, 1, BP,     1, 1, 1, 6);
        v(1, 0, 0, 0, 1, BP,     1, 1, 1, 7);
        v(1, 1, 0, 0, 1, BP,     1, 0, 0, 8);
        v(1, 1, 0, 0, 1, BP,     1, 1, 1, 8);
        v(1, 1, 0, 0, 1, BP + 4, 1, 1, 1, 9);
`endif

        @(posedge clk);
        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; run_sw = tbl[i].run; step_pulse = tbl[i].step;
            halt_req = tbl[i].halt; burst_len = tbl[i].bl; pc = tbl[i].pc; bp_en = tbl[i].bpe;
            e.st = tbl[i].st; e.cpu = tbl[i].cpu; e.cnt = tbl[i].cnt;
            sb.push_back(e);
            #1;
            e = sb.pop_front();
            chk("state",       i, 32'(state),       32'(e.st));
            chk("cpu_en",      i, 32'(cpu_en),      32'(e.cpu));
            chk("instr_count", i, 32'(instr_count), 32'(e.cnt));
            chk("halted",      i, 32'(halted),      32'((e.st == 2'd0) || (e.st == 2'd3)));
            chk("bp_hit",      i, 32'(bp_hit),      32'(e.st == 2'd3));
        end

        // Hand sequence: leave RUN, then a burst of 7 counted until HALT.
        base = int'(tbl[tbl.size()-1].cnt) + 2;
        @(negedge clk);
        run_sw = 1'b0; pc = '0; bp_en = 1'b0;
        @(negedge clk);
        step_pulse = 1'b1; burst_len = 8'd7;
        #1;
        chk("pre_burst_state", 0, 32'(state), 32'd0);
        @(negedge clk);
        step_pulse = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (state != 2'd2) break;
            if (cpu_en) n++;
            @(negedge clk);
        end
        exp_cnt = 4'(base + 7);
        chk("burst7_len",   0, 32'(n),           32'd7);
        chk("burst7_count", 0, 32'(instr_count), 32'(exp_cnt));
        chk("burst7_halt",  0, 32'(halted),      32'd1);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/step_ctrl.md
Name: step_ctrl

Overview:
- Run/step controller that sits directly downstream of the clock generator's single-step pulse.
- Consumes the one-cycle `step_pulse` (mipsclk domain) plus front-panel switches, and produces a per-cycle `cpu_en` that gates the MIPS core's state updates.
- Supports four modes: free-run, single-step, N-instruction burst, and an optional PC breakpoint halt.
- All logic runs on mipsclk.

Parameters:
- ADDR_W, 32, width of PC and breakpoint address
- BURST_W, 8, width of burst length input
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  mipsclk; all logic posedge
- rst  in  1  synchronous, active-low reset
- step_pulse  in  1  one-cycle step request, already debounced and pulsed
- run_sw  in  1  level; 1 = free-run requested
- halt_req  in  1  level; external halt, highest priority
- burst_len  in  BURST_W  instructions per step press; 0 is treated as 1
- pc  in  ADDR_W  PC of the instruction the core would execute this cycle
- bp_addr  in  ADDR_W  breakpoint address
- bp_en  in  1  breakpoint enable
- cpu_en  out  1  core advances one instruction in any cycle this is high
- halted  out  1  high in HALT or BREAK
- bp_hit  out  1  high while in BREAK
- state  out  2  current state encoding
- instr_count  out  CNT_W  count of cycles with cpu_en=1

Behaviour:
- Interface:
  - One clock, `clk`.
  - Reset `rst` is synchronous and active-low: sampled only on posedge `clk`, and `rst`=0 resets.
- Reset values:
  - state=HALT, remaining=0, skip=0, instr_count=0.
  - Outputs at reset: cpu_en=0, halted=1, bp_hit=0.
- Output timing:
  - state, remaining, skip and instr_count are registered.
  - cpu_en is combinational from registered state and the breakpoint compare (zero latency from pc).
- Breakpoint match: `match = bp_en & (pc == bp_addr) & ~skip`.
- States and encoding: HALT=0, RUN=1, BURST=2, BREAK=3.
- Transition priority within each state: halt_req, then match, then run_sw, then step_pulse.
- HALT:
  - cpu_en=0.
  - `~halt_req & run_sw` → RUN.
  - Else `~halt_req & step_pulse` → BURST, loading remaining = (burst_len==0 ? 1 : burst_len).
  - When run_sw and step_pulse arrive in the same cycle, RUN wins.
- RUN:
  - cpu_en = ~match & ~halt_req.
  - halt_req → HALT.
  - match → BREAK; the breakpoint instruction is not executed.
  - ~run_sw → HALT.
- BURST:
  - cpu_en = ~match & ~halt_req.
  - halt_req → HALT, remaining cleared.
  - match → BREAK, remaining cleared.
  - Otherwise remaining decrements; when remaining==1 on a cpu_en cycle → HALT.
  - step_pulse during BURST is ignored and not queued.
  - run_sw has no effect until BURST completes (HALT then enters RUN on the next cycle).
- BREAK:
  - cpu_en=0, bp_hit=1.
  - step_pulse → BURST (loading as in HALT).
  - ~run_sw → HALT.
  - halt_req → HALT.
  - Every exit from BREAK sets skip=1.
- skip flag:
  - Cleared on the first cycle with cpu_en=1.
  - Guarantees a resume executes the breakpoint instruction instead of re-trapping.
  - Cleared by reset.
- instr_count:
  - +1 on every cycle with cpu_en=1.
  - Wraps modulo 2^CNT_W with no saturation.
- Reset mid-burst or mid-run → HALT next edge; cpu_en drops in the reset cycle.

Optional Feature:
- Macro: STEP_CTRL_BREAKPOINT_EN.
- Defined: breakpoint logic as above.
- Undefined:
  - match is constant 0 and the skip register is removed.
  - BREAK is unreachable.
  - bp_hit is tied 0.
  - bp_addr/bp_en ports remain present but are ignored.
  - All other behaviour is identical.

Decomposition:
- Package step_ctrl_pkg:
  - state encoding constants (HALT/RUN/BURST/BREAK)
  - a 2-bit state typedef
  - default width constants
- One natural sub-module, step_bp_match:
  - holds the address compare and the skip flag
  - inputs: pc, bp_addr, bp_en, cpu_en, set_skip
  - output: match
  - instantiated only under STEP_CTRL_BREAKPOINT_EN.

Test Plan:
1. Reset: rst=0 for 2 cycles with run_sw=1 → cpu_en=0, halted=1, state=0, instr_count=0; rst=1 → state=RUN next edge, cpu_en=1 every cycle.
2. Burst: burst_len=5, one step_pulse from HALT → exactly 5 consecutive cpu_en cycles, instr_count=5, then HALT; second pulse mid-burst ignored (still 5).
3. burst_len=0: step_pulse → exactly 1 cpu_en cycle, then HALT.
4. Breakpoint (macro on): RUN, bp_en=1, bp_addr=0x0040_0010, pc reaches 0x0040_0010 → cpu_en=0 that cycle, state=BREAK, bp_hit=1; step_pulse with burst_len=1 → one cpu_en with pc=0x0040_0010, back to HALT.
5. halt_req=1 mid-BURST (remaining=3) → cpu_en=0 same cycle, HALT next edge; deassert halt_req and pulse → fresh burst of burst_len.
6. Wrap: preload instr_count near max (CNT_W=4 build), run 3 cycles from 14 → 15, 0, 1.
